// File: rtl/ercm8_v2_2.sv
// Error-configurable approximate 8x8 unsigned multiplier, two-stage registered.
// Masked low columns (0..6) collapse to the OR of their partial products and emit no carry.

module ercm8_v2_2_col #(
   parameter int C = 0
) (
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   input  logic        approx,
   output logic [15:0] term
);
   // b padded on both sides so b_ext[C-i+7] reads as zero outside the column
   logic [21:0] b_ext;
   logic [3:0]  pop;
   logic        any;

   assign b_ext = {7'b0, b, 7'b0};

   always_comb begin
      pop = '0;
      for (int i = 0; i < 8; i++) begin
         pop = pop + {3'b0, a[i] & b_ext[C - i + 7]};
      end
      any  = |pop;
      term = approx ? (16'(any) << C) : (16'(pop) << C);
   end
endmodule

module ercm8_v2_2 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_vld,
   input  logic [7:0]  dat_in_a,
   input  logic [7:0]  dat_in_b,
   input  logic [6:0]  mask,
   output logic        out_vld,
   output logic [15:0] dat_o
);
   localparam int STAGES = 2;
   localparam int NCOL   = 15;

   logic [7:0]             a_q;
   logic [7:0]             b_q;
   logic [6:0]             mask_q;
   logic [STAGES:1]        vld_pipe;
   logic [NCOL-1:0]        col_approx;
   logic [NCOL-1:0][15:0]  col_term;
   logic [15:0]            prod;

   // Columns 7..14 are always exact; the mask only reaches the low seven.
   for (genvar c = 0; c < NCOL; c++) begin : g_col
      if (c < 7) begin : g_msk
         assign col_approx[c] = mask_q[c];
      end else begin : g_exact
         assign col_approx[c] = 1'b0;
      end
      ercm8_v2_2_col #(.C(c)) u_col (
         .a      (a_q),
         .b      (b_q),
         .approx (col_approx[c]),
         .term   (col_term[c])
      );
   end

   // Weighted column contributions summed with full carry propagation.
   always_comb begin
      prod = '0;
      for (int c = 0; c < NCOL; c++) begin
         prod = prod + col_term[c];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q      <= '0;
         b_q      <= '0;
         mask_q   <= '0;
         vld_pipe <= '0;
         dat_o    <= '0;
      end else begin
         vld_pipe <= {vld_pipe[STAGES-1:1], in_vld};
         if (in_vld) begin
            a_q    <= dat_in_a;
            b_q    <= dat_in_b;
            mask_q <= mask;
         end
         if (vld_pipe[1]) dat_o <= prod;
      end
   end

   assign out_vld = vld_pipe[STAGES];
endmodule

// File: tb/tb_ercm8_v2_2.sv
// Self-checking bench for ercm8_v2_2: directed vectors, random sweep vs column model,
// asynchronous reset mid-stream and pipeline bubbles.
module tb_ercm8_v2_2;
   logic        clk;
   logic        rst_n;
   logic        in_vld;
   logic [7:0]  dat_in_a;
   logic [7:0]  dat_in_b;
   logic [6:0]  mask;
   logic        out_vld;
   logic [15:0] dat_o;

   int n_checks = 0;
   int n_errors = 0;

   localparam int NSWEEP = 10000;

   ercm8_v2_2 dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_vld   (in_vld),
      .dat_in_a (dat_in_a),
      .dat_in_b (dat_in_b),
      .mask     (mask),
      .out_vld  (out_vld),
      .dat_o    (dat_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: weighted popcount per column, masked low columns reduced to OR.
   function automatic logic [15:0] golden(input logic [7:0] a, input logic [7:0] b,
                                          input logic [6:0] m);
      int acc;
      acc = 0;
      for (int c = 0; c < 15; c++) begin
         int cnt;
         cnt = 0;
         for (int i = 0; i < 8; i++) begin
            int j;
            j = c - i;
            if (j >= 0 && j < 8) begin
               if (a[i] && b[j]) cnt++;
            end
         end
         if (c < 7 && m[c]) acc += ((cnt > 0) ? 1 : 0) << c;
         else               acc += cnt << c;
      end
      return 16'(acc);
   endfunction

   task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [6:0] m,
                        input logic v);
      dat_in_a = a;
      dat_in_b = b;
      mask     = m;
      in_vld   = v;
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_checks++;
      if (dat_o !== 16'd0) begin
         n_errors++;
         $display("FAIL reset_dat_o: got %0d expected 0", dat_o);
      end
      n_checks++;
      if (out_vld !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_out_vld: got %0b expected 0", out_vld);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_directed();
      logic [7:0]  va [6] = '{8'd255, 8'd13, 8'd255, 8'd0,   8'd255, 8'd255};
      logic [7:0]  vb [6] = '{8'd255, 8'd11, 8'd255, 8'd200, 8'd255, 8'd255};
      logic [6:0]  vm [6] = '{7'h00,  7'h00, 7'h7F,  7'h7F,  7'h01,  7'h02};
      logic [15:0] ve [6] = '{16'd65025, 16'd143, 16'd64383, 16'd0, 16'd65025, 16'd65023};
      for (int k = 0; k < 6; k++) begin
         issue(va[k], vb[k], vm[k], 1'b1);
         @(negedge clk);
         issue(8'd0, 8'd0, 7'd0, 1'b0);
         n_checks++;
         if (out_vld !== 1'b0) begin
            n_errors++;
            $display("FAIL directed%0d_early_vld: got %0b expected 0", k, out_vld);
         end
         @(negedge clk);
         n_checks++;
         if (out_vld !== 1'b1) begin
            n_errors++;
            $display("FAIL directed%0d_vld: got %0b expected 1", k, out_vld);
         end
         n_checks++;
         if (dat_o !== ve[k]) begin
            n_errors++;
            $display("FAIL directed%0d_dat: A=%0d B=%0d mask=%h got %0d expected %0d",
                     k, va[k], vb[k], vm[k], dat_o, ve[k]);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_random_sweep();
      logic [15:0] exp_q [$];
      logic [15:0] ab_q  [$];
      logic        m0_q  [$];
      int issued = 0, got = 0, cyc = 0;
      int n_err = 0, m0_err = 0, max_ed = 0;
      longint sum_ed = 0;
      logic [7:0] a, b;
      logic [6:0] m;
      while (got < NSWEEP && cyc < NSWEEP + 50) begin
         @(negedge clk);
         cyc++;
         if (out_vld === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_errors++;
               $display("FAIL sweep_spurious_vld: got out_vld=1 expected no pending result");
            end else begin
               logic [15:0] e, p;
               logic        z;
               int ed;
               e = exp_q.pop_front();
               p = ab_q.pop_front();
               z = m0_q.pop_front();
               got++;
               if (dat_o !== e) begin
                  n_errors++;
                  $display("FAIL sweep_dat #%0d: got %0d expected %0d", got, dat_o, e);
               end
               n_checks++;
               if (dat_o > p) begin
                  n_errors++;
                  $display("FAIL sweep_bound #%0d: got %0d expected <= %0d", got, dat_o, p);
               end
               ed = int'(p) - int'(dat_o);
               if (ed != 0) n_err++;
               if (z && ed != 0) m0_err++;
               sum_ed += longint'(ed < 0 ? -ed : ed);
               if (ed > max_ed) max_ed = ed;
            end
         end
         if (issued < NSWEEP) begin
            a = 8'($urandom);
            b = 8'($urandom);
            m = ($urandom_range(3) == 0) ? 7'd0 : 7'($urandom);
            issue(a, b, m, 1'b1);
            exp_q.push_back(golden(a, b, m));
            ab_q.push_back(16'(a) * 16'(b));
            m0_q.push_back(m == 7'd0);
            issued++;
         end else begin
            issue(8'd0, 8'd0, 7'd0, 1'b0);
         end
      end
      n_checks++;
      if (got != NSWEEP) begin
         n_errors++;
         $display("FAIL sweep_count: got %0d results expected %0d", got, NSWEEP);
      end
      n_checks++;
      if (m0_err != 0) begin
         n_errors++;
         $display("FAIL sweep_mask0_exact: got %0d inexact results expected 0", m0_err);
      end
      $display("sweep: %0d samples, inexact %0d, mean error distance %f, max error %0d",
               got, n_err, (got > 0) ? real'(sum_ed) / real'(got) : 0.0, max_ed);
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      issue(8'd200, 8'd100, 7'd0, 1'b1);
      @(negedge clk);
      issue(8'd50, 8'd60, 7'h15, 1'b1);
      @(posedge clk);
      #2;
      issue(8'd0, 8'd0, 7'd0, 1'b0);
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (dat_o !== 16'd0) begin
         n_errors++;
         $display("FAIL rstmid_dat_async: got %0d expected 0", dat_o);
      end
      n_checks++;
      if (out_vld !== 1'b0) begin
         n_errors++;
         $display("FAIL rstmid_vld_async: got %0b expected 0", out_vld);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (out_vld !== 1'b0) begin
         n_errors++;
         $display("FAIL rstmid_flushed: got %0b expected 0", out_vld);
      end
      issue(8'd3, 8'd5, 7'd0, 1'b1);
      @(negedge clk);
      issue(8'd0, 8'd0, 7'd0, 1'b0);
      n_checks++;
      if (out_vld !== 1'b0) begin
         n_errors++;
         $display("FAIL rstmid_early_vld: got %0b expected 0", out_vld);
      end
      @(negedge clk);
      n_checks++;
      if (out_vld !== 1'b1 || dat_o !== 16'd15) begin
         n_errors++;
         $display("FAIL rstmid_first: got vld=%0b dat=%0d expected vld=1 dat=15", out_vld, dat_o);
      end
      @(negedge clk);
   endtask

   task automatic test_bubbles();
      logic        ev [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      logic [15:0] ed [4] = '{16'd6, 16'd6, 16'd16, 16'd16};
      issue(8'd2, 8'd3, 7'd0, 1'b1);
      @(negedge clk);
      issue(8'd0, 8'd0, 7'd0, 1'b0);
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (out_vld !== ev[k] || dat_o !== ed[k]) begin
            n_errors++;
            $display("FAIL bubble%0d: got vld=%0b dat=%0d expected vld=%0b dat=%0d",
                     k, out_vld, dat_o, ev[k], ed[k]);
         end
         if (k == 0) issue(8'd4, 8'd4, 7'd0, 1'b1);
         else        issue(8'd0, 8'd0, 7'd0, 1'b0);
         @(negedge clk);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      issue(8'd0, 8'd0, 7'd0, 1'b0);
      test_reset();
      test_directed();
      test_bubbles();
      test_random_sweep();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
